// File: rtl/relu_quant_maxpool.sv
// ReLU + shift requantization to unsigned 8-bit, then 2x2 stride-2 max pooling
// over a raster-ordered CONV_WIDTH x CONV_WIDTH conv result stream.
module relu_quant_maxpool #(
   parameter int IN_WIDTH   = 32,
   parameter int CONV_WIDTH = 24,
   parameter int OUT_WIDTH  = 8,
   parameter int SHIFT      = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 valid_in,
   input  logic [IN_WIDTH-1:0]  data_in,
   output logic [OUT_WIDTH-1:0] pool_out,
   output logic                 pool_valid,
   output logic                 frame_done
);

   localparam int CW   = $clog2(CONV_WIDTH);
   localparam int HALF = CONV_WIDTH / 2;
   localparam logic [CW-1:0] LAST = CW'(CONV_WIDTH - 1);
   localparam logic signed [IN_WIDTH-1:0] SAT_MAX = IN_WIDTH'((1 << OUT_WIDTH) - 1);

   function automatic logic [OUT_WIDTH-1:0] relu_quant(input logic signed [IN_WIDTH-1:0] x);
      logic signed [IN_WIDTH-1:0] sh;
      sh = x >>> SHIFT;
      if (x[IN_WIDTH-1])
         relu_quant = '0;
      else if (sh > SAT_MAX)
         relu_quant = '1;
      else
         relu_quant = sh[OUT_WIDTH-1:0];
   endfunction

   function automatic logic [OUT_WIDTH-1:0] umax(input logic [OUT_WIDTH-1:0] a,
                                                 input logic [OUT_WIDTH-1:0] b);
      umax = (a > b) ? a : b;
   endfunction

   logic signed [IN_WIDTH-1:0] din_s;
   assign din_s = data_in;

   logic [CW-1:0]        col_q, col_d, row_q, row_d;
   logic                 vld_p1_q, vld_p1_d;
   logic [OUT_WIDTH-1:0] pix_p1_q, pix_p1_d;
   logic [CW-1:0]        col_p1_q, col_p1_d, row_p1_q, row_p1_d;
   logic [OUT_WIDTH-1:0] hold_q, hold_d;
   logic [OUT_WIDTH-1:0] pool_out_q, pool_out_d;
   logic                 pool_valid_q, pool_valid_d;
   logic                 frame_done_q, frame_done_d;
   logic [OUT_WIDTH-1:0] linebuf_q [HALF];
   logic [CW-2:0]        lb_idx;
   logic [OUT_WIDTH-1:0] pm;
   logic                 lb_we;

   assign lb_idx = col_p1_q[CW-1:1];
   assign pm     = umax(hold_q, pix_p1_q);

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      vld_p1_d     = 1'b0;
      pix_p1_d     = pix_p1_q;
      col_p1_d     = col_p1_q;
      row_p1_d     = row_p1_q;
      hold_d       = hold_q;
      pool_out_d   = pool_out_q;
      pool_valid_d = 1'b0;
      frame_done_d = 1'b0;
      lb_we        = 1'b0;
      if (clear) begin
         col_d  = '0;
         row_d  = '0;
         hold_d = '0;
      end else begin
         // Stage 0 -> 1: quantize and tag with raster position
         if (valid_in) begin
            vld_p1_d = 1'b1;
            pix_p1_d = relu_quant(din_s);
            col_p1_d = col_q;
            row_p1_d = row_q;
            if (col_q == LAST) begin
               col_d = '0;
               row_d = (row_q == LAST) ? '0 : row_q + 1'b1;
            end else begin
               col_d = col_q + 1'b1;
            end
         end
         // Stage 1 -> 2: horizontal pair max, then vertical via line buffer
         if (vld_p1_q) begin
            if (!col_p1_q[0]) begin
               hold_d = pix_p1_q;
            end else if (!row_p1_q[0]) begin
               lb_we = 1'b1;
            end else begin
               pool_out_d   = umax(linebuf_q[lb_idx], pm);
               pool_valid_d = 1'b1;
               frame_done_d = (row_p1_q == LAST) && (col_p1_q == LAST);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q        <= '0;
         row_q        <= '0;
         vld_p1_q     <= 1'b0;
         hold_q       <= '0;
         pool_out_q   <= '0;
         pool_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         vld_p1_q     <= vld_p1_d;
         hold_q       <= hold_d;
         pool_out_q   <= pool_out_d;
         pool_valid_q <= pool_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Datapath-only storage; the line buffer is always written on an even row before use
   always_ff @(posedge clk) begin
      pix_p1_q <= pix_p1_d;
      col_p1_q <= col_p1_d;
      row_p1_q <= row_p1_d;
      if (lb_we)
         linebuf_q[lb_idx] <= pm;
   end

   assign pool_out   = pool_out_q;
   assign pool_valid = pool_valid_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_relu_quant_maxpool.sv
// Bench for relu_quant_maxpool: frame-level reference model, vector table,
// and hand sequences for latency, clear and mid-frame reset.
module tb_relu_quant_maxpool;

   localparam int W  = 24;
   localparam int SH = 8;

   logic        clk = 1'b0;
   logic        rst_n, clear, valid_in;
   logic [31:0] data_in;
   logic [7:0]  pool_out;
   logic        pool_valid, frame_done;

   always #5 clk = ~clk;

   relu_quant_maxpool #(.IN_WIDTH(32), .CONV_WIDTH(W), .OUT_WIDTH(8), .SHIFT(SH)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .valid_in(valid_in), .data_in(data_in),
      .pool_out(pool_out), .pool_valid(pool_valid), .frame_done(frame_done)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // capture of every pooled pulse as {frame_done, pool_out}
   logic [8:0] cap[$];
   int stray = 0;
   always @(posedge clk) begin
      #1;
      if (pool_valid) cap.push_back({frame_done, pool_out});
      else if (frame_done) stray++;
   end

   // reference model state
   int fr[W][W];
   int mr = 0, mc = 0;
   logic [8:0] exp_q[$];
   int mark = 0;

   typedef struct {
      string name;
      int    v[4];
      int    want;
   } vec_t;
   vec_t tbl[10];

   function automatic int mq(input int x);
      if (x < 0) return 0;
      if (x / (1 << SH) > 255) return 255;
      return x / (1 << SH);
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic void chk(input string name, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endfunction

   task automatic send(input int x);
      int m;
      @(negedge clk);
      clear    = 1'b0;
      valid_in = 1'b1;
      data_in  = x;
      fr[mr][mc] = x;
      if ((mr % 2 == 1) && (mc % 2 == 1)) begin
         m = imax(imax(mq(fr[mr-1][mc-1]), mq(fr[mr-1][mc])), imax(mq(fr[mr][mc-1]), mq(x)));
         exp_q.push_back({(mr == W-1) && (mc == W-1), m[7:0]});
      end
      if (mc == W-1) begin
         mc = 0;
         mr = (mr == W-1) ? 0 : mr + 1;
      end else begin
         mc++;
      end
   endtask

   task automatic idle();
      @(negedge clk);
      valid_in = 1'b0;
   endtask

   task automatic drain();
      idle();
      repeat (4) @(posedge clk);
      #2;
   endtask

   task automatic model_reset();
      mr = 0;
      mc = 0;
      exp_q.delete();
   endtask

   task automatic check_outputs(input string name);
      int n;
      n = cap.size() - mark;
      chk({name, "_count"}, n, exp_q.size());
      for (int i = 0; i < exp_q.size() && i < n; i++)
         chk($sformatf("%s_px%0d", name, i), int'(cap[mark+i]), int'(exp_q[i]));
      exp_q.delete();
      mark = cap.size();
   endtask

   task automatic ramp(input int n);
      for (int i = 0; i < n; i++) send((i % (W*W)) << 8);
   endtask

   task automatic do_clear(input bit with_valid);
      @(negedge clk);
      clear    = 1'b1;
      valid_in = with_valid;
      data_in  = 32'h7fff_0000;
      mark     = cap.size();
      @(negedge clk);
      clear    = 1'b0;
      valid_in = 1'b0;
      model_reset();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      valid_in = 1'b0;
      mark     = cap.size();
      @(negedge clk);
      rst_n    = 1'b1;
      model_reset();
   endtask

   task automatic set_vec(input int i, input string nm, input int a, input int b,
                          input int c, input int d, input int want);
      tbl[i].name = nm;
      tbl[i].v[0] = a;
      tbl[i].v[1] = b;
      tbl[i].v[2] = c;
      tbl[i].v[3] = d;
      tbl[i].want = want;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int m0, x;
      set_vec(0, "relu_sat_mix", -5000, 300 << 8, 10 << 8, -1, 255);
      set_vec(1, "all_neg",      -1, -1, -1, -1, 0);
      set_vec(2, "all_maxint",   32'h7fffffff, 32'h7fffffff, 32'h7fffffff, 32'h7fffffff, 255);
      set_vec(3, "max_tl",       200 << 8, 7 << 8, 7 << 8, 7 << 8, 200);
      set_vec(4, "max_tr",       7 << 8, 200 << 8, 7 << 8, 7 << 8, 200);
      set_vec(5, "max_bl",       7 << 8, 7 << 8, 200 << 8, 7 << 8, 200);
      set_vec(6, "max_br",       7 << 8, 7 << 8, 7 << 8, 200 << 8, 200);
      set_vec(7, "sat_edge",     (256 << 8) - 1, 3 << 8, 0, 0, 255);
      set_vec(8, "sat_over",     256 << 8, 0, 0, 0, 255);
      set_vec(9, "truncate",     255, 254, 1, 0, 0);

      rst_n = 1'b0; clear = 1'b0; valid_in = 1'b0; data_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_pool_out", pool_out, 0);
      chk("reset_pool_valid", pool_valid, 0);
      chk("reset_frame_done", frame_done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      mark  = cap.size();

      // ramp frame
      m0 = mark;
      ramp(W*W);
      drain();
      chk("ramp_first", int'(cap[m0][7:0]), 25);
      chk("ramp_last", int'(cap[m0+143]), 9'h1ff);
      check_outputs("ramp");

      // vector table: block (0,0) from table, remainder of frame zero
      for (int t = 0; t < 10; t++) begin
         m0 = mark;
         for (int r = 0; r < W; r++)
            for (int c = 0; c < W; c++)
               send((r < 2 && c < 2) ? tbl[t].v[r*2+c] : 0);
         drain();
         chk({tbl[t].name, "_blk"}, int'(cap[m0][7:0]), tbl[t].want);
         check_outputs(tbl[t].name);
      end

      // latency: pool_valid appears after the second edge following the odd/odd input
      for (int c = 0; c < W; c++) send(7 << 8);
      send(7 << 8);
      send(200 << 8);
      @(posedge clk);
      #1;
      chk("lat_edge1_valid", pool_valid, 0);
      valid_in = 1'b0;
      @(posedge clk);
      #1;
      chk("lat_edge2_valid", pool_valid, 1);
      chk("lat_edge2_pix", pool_out, 200);
      for (int i = W + 2; i < W*W; i++) send(7 << 8);
      drain();
      check_outputs("latency");

      // random data frame
      for (int i = 0; i < W*W; i++) begin
         x = int'($urandom) >>> $urandom_range(0, 24);
         send(x);
      end
      drain();
      check_outputs("random");

      // sparse valid, constant data
      m0 = mark;
      for (int i = 0; i < W*W; i++) begin
         send(50 << 8);
         repeat ($urandom_range(0, 3)) idle();
      end
      drain();
      chk("sparse_first", int'(cap[m0]), 50);
      chk("sparse_last", int'(cap[m0+143]), 9'h100 | 50);
      check_outputs("sparse");

      // back-to-back frames
      m0 = mark;
      ramp(2*W*W);
      drain();
      chk("b2b_f1_done", int'(cap[m0+143][8]), 1);
      chk("b2b_f2_first", int'(cap[m0+144]), 25);
      check_outputs("b2b");

      // mid-frame asynchronous reset
      ramp(300);
      do_reset();
      ramp(W*W);
      drain();
      check_outputs("midreset");

      // mid-frame clear, with a valid_in presented alongside clear
      ramp(300);
      do_clear(1'b1);
      ramp(W*W);
      drain();
      check_outputs("midclear");

      chk("stray_frame_done", stray, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
